// File: rtl/foo_pkg.sv
// Shared types for the foo stream sequence checker: data word type, checker state, data width.
package foo_pkg;
  localparam int FOO_DATA_W = 32;

  typedef logic [FOO_DATA_W-1:0] data_s;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } foo_chk_state_e;
endpackage

// File: rtl/foo_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of rolling over.
module foo_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // clear takes priority over a same-cycle increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/foo_seq_checker.sv
// Incrementing-sequence checker for the foo_if data stream; FOO_SEQ_CHECKER_RESYNC_EN makes a
// locked mismatch fall back to ACQ instead of free-running the expected value.
//   state  | meaning
//   IDLE   | checker disabled, nothing tracked
//   ACQ    | searching for LOCK_CNT consecutive +STEP words
//   LOCKED | stream tracked; matches and mismatches are counted
module foo_seq_checker
  import foo_pkg::*;
#(
  parameter int    CNT_W    = 16,
  parameter int    LOCK_CNT = 2,
  parameter data_s STEP     = 32'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  data_s            data_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output data_s            expected,
  output data_s            last_data
);
  localparam logic [8:0] LOCK_TGT = 9'(LOCK_CNT);

  foo_chk_state_e state_q, state_d;
  logic [7:0]     run_q, run_d;
  data_s          expected_q, expected_d;
  data_s          last_q, last_d;
  logic           err_pulse_q, err_pulse_d;
  logic           match_inc, err_inc;
  logic           seq_miss, lock_hit;

  // !== so that X/Z on the bus while locked is flagged as a mismatch
  assign seq_miss = (data_in !== expected_q);
  assign lock_hit = (({1'b0, run_q} + 9'd1) == LOCK_TGT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      run_q       <= '0;
      expected_q  <= '0;
      last_q      <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      expected_q  <= expected_d;
      last_q      <= last_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ACQ;
        ACQ:     if (!seq_miss && lock_hit) state_d = LOCKED;
        LOCKED: begin
`ifdef FOO_SEQ_CHECKER_RESYNC_EN
          if (seq_miss) state_d = ACQ;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    run_d       = run_q;
    expected_d  = expected_q;
    last_d      = enable ? data_in : last_q;
    match_inc   = 1'b0;
    err_inc     = 1'b0;
    if (enable) begin
      case (state_q)
        IDLE: begin
          expected_d = data_in + STEP;
          run_d      = '0;
        end
        ACQ: begin
          if (!seq_miss) begin
            run_d      = run_q + 8'd1;
            expected_d = expected_q + STEP;
          end else begin
            run_d      = '0;
            expected_d = data_in + STEP;
          end
        end
        LOCKED: begin
          if (!seq_miss) begin
            match_inc  = 1'b1;
            expected_d = expected_q + STEP;
          end else begin
            err_inc = 1'b1;
`ifdef FOO_SEQ_CHECKER_RESYNC_EN
            expected_d = data_in + STEP;
            run_d      = '0;
`else
            expected_d = expected_q + STEP;
`endif
          end
        end
        default: begin
          run_d      = '0;
          expected_d = expected_q;
        end
      endcase
    end
    err_pulse_d = err_inc;
  end

  foo_sat_cnt #(.CNT_W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (match_inc),
    .clr_i (clear),
    .cnt_o (match_cnt)
  );

  foo_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (err_inc),
    .clr_i (clear),
    .cnt_o (err_cnt)
  );

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign expected  = expected_q;
  assign last_data = last_q;
endmodule

// File: tb/tb_foo_seq_checker.sv
// Bench for foo_seq_checker: directed scenarios plus a randomized run against a stream model;
// a narrow-counter instance shares the stimulus to exercise saturation.
module tb_foo_seq_checker;
  localparam int LOCK_CNT = 2;
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2;

  logic        clk = 1'b0;
  logic        rst, enable, clear;
  logic [31:0] data_in;
  logic        locked, err_pulse;
  logic [15:0] match_cnt, err_cnt;
  logic [31:0] expected, last_data;
  logic        locked4, err_pulse4;
  logic [3:0]  match_cnt4, err_cnt4;
  logic [31:0] expected4, last_data4;

  foo_seq_checker #(.CNT_W(16), .LOCK_CNT(LOCK_CNT), .STEP(32'd1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .data_in(data_in),
    .locked(locked), .err_pulse(err_pulse), .match_cnt(match_cnt), .err_cnt(err_cnt),
    .expected(expected), .last_data(last_data));

  foo_seq_checker #(.CNT_W(4), .LOCK_CNT(LOCK_CNT), .STEP(32'd1)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .data_in(data_in),
    .locked(locked4), .err_pulse(err_pulse4), .match_cnt(match_cnt4), .err_cnt(err_cnt4),
    .expected(expected4), .last_data(last_data4));

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;

  // stream model: how many words in a row have followed +1, what comes next, tallies since clear
  int          m_mode, m_run, m_match, m_err;
  logic [31:0] m_exp, m_last;
  bit          m_pulse;

  function automatic int sat4(input int c);
    return (c > 15) ? 15 : c;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_run = 0; m_match = 0; m_err = 0;
    m_exp = '0; m_last = '0; m_pulse = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; enable = 1'b0; clear = 1'b0; data_in = $urandom;
    repeat (n) @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic step(input bit en, input bit clr, input logic [31:0] d);
    enable = en; clear = clr; data_in = d; rst = 1'b0;
    @(posedge clk);
    m_pulse = 0;
    if (!en) begin
      m_mode = M_IDLE;
    end else begin
      m_last = d;
      if (m_mode == M_IDLE) begin
        m_exp = d + 32'd1; m_run = 0; m_mode = M_ACQ;
      end else if (m_mode == M_ACQ) begin
        if (d === m_exp) begin
          m_run++; m_exp = m_exp + 32'd1;
          if (m_run >= LOCK_CNT) m_mode = M_LOCK;
        end else begin
          m_exp = d + 32'd1; m_run = 0;
        end
      end else begin
        if (d === m_exp) begin
          m_match++; m_exp = m_exp + 32'd1;
        end else begin
          m_err++; m_pulse = 1;
`ifdef FOO_SEQ_CHECKER_RESYNC_EN
          m_exp = d + 32'd1; m_run = 0; m_mode = M_ACQ;
`else
          m_exp = m_exp + 32'd1;
`endif
        end
      end
    end
    if (clr) begin m_match = 0; m_err = 0; end
    #1;
  endtask

  task automatic test_reset();
    do_reset(2);
    tests_run++;
    if ({locked, err_pulse, match_cnt, err_cnt, expected, last_data} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got l=%b p=%b m=%h e=%h x=%h d=%h want all zero",
               locked, err_pulse, match_cnt, err_cnt, expected, last_data);
    end
  endtask

  task automatic test_lock();
    logic [31:0] w;
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      w = 32'hcafedeca + 32'(i);
      step(1'b1, 1'b0, w);
      if (i == 1) begin
        tests_run++;
        if (locked !== 1'b0) begin fails++; $display("FAIL lock_early got %b want 0", locked); end
      end
      if (i == 2) begin
        tests_run++;
        if (locked !== 1'b1) begin fails++; $display("FAIL lock_third got %b want 1", locked); end
      end
    end
    tests_run++;
    if (match_cnt !== 16'd7 || err_cnt !== 16'd0) begin
      fails++; $display("FAIL lock_counts got m=%0d e=%0d want m=7 e=0", match_cnt, err_cnt);
    end
    tests_run++;
    if (expected !== 32'hcafeded4 || last_data !== 32'hcafeded3) begin
      fails++; $display("FAIL lock_expected got x=%h d=%h want x=cafeded4 d=cafeded3", expected, last_data);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] w;
    int pulses = 0;
    do_reset(1);
    step(1'b1, 1'b0, 32'hFFFFFFFB);
    step(1'b1, 1'b0, 32'hFFFFFFFC);
    step(1'b1, 1'b0, 32'hFFFFFFFD);
    for (int i = 0; i < 4; i++) begin
      w = 32'hFFFFFFFE + 32'(i);
      step(1'b1, 1'b0, w);
      if (err_pulse !== 1'b0) pulses++;
    end
    tests_run++;
    if (pulses != 0 || match_cnt !== 16'd4 || locked !== 1'b1 || expected !== 32'd2) begin
      fails++;
      $display("FAIL wrap got pulses=%0d m=%0d l=%b x=%h want pulses=0 m=4 l=1 x=2",
               pulses, match_cnt, locked, expected);
    end
  endtask

  task automatic test_corrupt();
    int pulses = 0;
    int want_m;
    logic want_l;
    do_reset(1);
    step(1'b1, 1'b0, 32'd97);
    step(1'b1, 1'b0, 32'd98);
    step(1'b1, 1'b0, 32'd99);
    step(1'b1, 1'b0, 32'd100);
    step(1'b1, 1'b0, 32'd101);
    step(1'b1, 1'b0, 32'hDEAD);
    tests_run++;
    if (err_pulse !== 1'b1) begin fails++; $display("FAIL corrupt_pulse got %b want 1", err_pulse); end
    step(1'b1, 1'b0, 32'd103);
    if (err_pulse) pulses++;
    step(1'b1, 1'b0, 32'd104);
    if (err_pulse) pulses++;
`ifdef FOO_SEQ_CHECKER_RESYNC_EN
    want_m = 2; want_l = 1'b0;
`else
    want_m = 4; want_l = 1'b1;
`endif
    tests_run++;
    if (err_cnt !== 16'd1 || match_cnt !== 16'(want_m) || pulses != 0 || locked !== want_l) begin
      fails++;
      $display("FAIL corrupt_after got e=%0d m=%0d extra_pulses=%0d l=%b want e=1 m=%0d extra_pulses=0 l=%b",
               err_cnt, match_cnt, pulses, locked, want_m, want_l);
    end
    step(1'b1, 1'b0, 32'd105);
    tests_run++;
    if (locked !== 1'b1 || err_cnt !== 16'd1) begin
      fails++; $display("FAIL corrupt_relock got l=%b e=%0d want l=1 e=1", locked, err_cnt);
    end
  endtask

  task automatic test_acq_glitch();
    int pulses = 0;
    do_reset(1);
    step(1'b1, 1'b0, 32'd5);  if (err_pulse) pulses++;
    step(1'b1, 1'b0, 32'd6);  if (err_pulse) pulses++;
    step(1'b1, 1'b0, 32'd9);  if (err_pulse) pulses++;
    step(1'b1, 1'b0, 32'd10); if (err_pulse) pulses++;
    tests_run++;
    if (locked !== 1'b0) begin fails++; $display("FAIL glitch_early got l=%b want 0", locked); end
    step(1'b1, 1'b0, 32'd11); if (err_pulse) pulses++;
    tests_run++;
    if (locked !== 1'b1 || err_cnt !== 16'd0 || pulses != 0 || expected !== 32'd12) begin
      fails++;
      $display("FAIL glitch_lock got l=%b e=%0d pulses=%0d x=%0d want l=1 e=0 pulses=0 x=12",
               locked, err_cnt, pulses, expected);
    end
  endtask

  task automatic test_clear();
    do_reset(1);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 32'(i));
    tests_run++;
    if (match_cnt !== 16'd2) begin fails++; $display("FAIL clear_pre got m=%0d want 2", match_cnt); end
    step(1'b1, 1'b1, 32'd999);
    tests_run++;
    if (err_pulse !== 1'b1 || err_cnt !== 16'd0 || match_cnt !== 16'd0) begin
      fails++;
      $display("FAIL clear_vs_err got p=%b e=%0d m=%0d want p=1 e=0 m=0", err_pulse, err_cnt, match_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset(1);
    for (int i = 0; i < 23; i++) step(1'b1, 1'b0, 32'(i));
    tests_run++;
    if (match_cnt4 !== 4'hF || match_cnt !== 16'd20) begin
      fails++; $display("FAIL saturate got m4=%h m16=%0d want m4=f m16=20", match_cnt4, match_cnt);
    end
  endtask

  task automatic test_enable_rst();
    do_reset(1);
    for (int i = 10; i <= 14; i++) step(1'b1, 1'b0, 32'(i));
    step(1'b0, 1'b0, 32'd55);
    tests_run++;
    if (locked !== 1'b0 || match_cnt !== 16'd2 || expected !== 32'd15 || last_data !== 32'd14) begin
      fails++;
      $display("FAIL enable_low got l=%b m=%0d x=%0d d=%0d want l=0 m=2 x=15 d=14",
               locked, match_cnt, expected, last_data);
    end
    step(1'b1, 1'b0, 32'd77);
    step(1'b1, 1'b0, 32'd78);
    step(1'b1, 1'b0, 32'd79);
    tests_run++;
    if (locked !== 1'b1 || match_cnt !== 16'd2) begin
      fails++; $display("FAIL enable_relock got l=%b m=%0d want l=1 m=2", locked, match_cnt);
    end
    rst = 1'b1; enable = 1'b1; clear = 1'b0; data_in = 32'd80;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tests_run++;
    if ({locked, err_pulse, match_cnt, err_cnt, expected, last_data} !== '0) begin
      fails++;
      $display("FAIL rst_locked got l=%b p=%b m=%h e=%h x=%h d=%h want all zero",
               locked, err_pulse, match_cnt, err_cnt, expected, last_data);
    end
  endtask

  task automatic test_random();
    bit          en, clr;
    logic [31:0] d;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1);
      end else begin
        en  = ($urandom_range(0, 99) >= 6);
        clr = ($urandom_range(0, 59) == 0);
        d   = ($urandom_range(0, 9) < 8) ? m_exp : 32'($urandom);
        step(en, clr, d);
      end
      tests_run++;
      if (locked !== (m_mode == M_LOCK) || err_pulse !== m_pulse ||
          match_cnt !== 16'(m_match) || err_cnt !== 16'(m_err) ||
          expected !== m_exp || last_data !== m_last ||
          match_cnt4 !== 4'(sat4(m_match)) || err_cnt4 !== 4'(sat4(m_err))) begin
        fails++;
        $display("FAIL random[%0d] got l=%b p=%b m=%0d e=%0d x=%h d=%h m4=%0d e4=%0d want l=%b p=%b m=%0d e=%0d x=%h d=%h m4=%0d e4=%0d",
                 n, locked, err_pulse, match_cnt, err_cnt, expected, last_data, match_cnt4, err_cnt4,
                 (m_mode == M_LOCK), m_pulse, m_match, m_err, m_exp, m_last, sat4(m_match), sat4(m_err));
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0; data_in = '0;
    model_reset();
    test_reset();
    test_lock();
    test_wrap();
    test_corrupt();
    test_acq_glitch();
    test_clear();
    test_saturation();
    test_enable_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/foo_seq_checker.md
Name: foo_seq_checker

Overview:
- Downstream consumer of the foo_if data stream: samples the 32-bit data_s word once per clock and checks it against an incrementing-sequence model.
- Acquires lock on the stream, then flags and counts every word that breaks the +1 sequence.
- Provides synthesizable, registered status that runs alongside the simulation monitor. Usable in emulation and as a self-check in top-level benches.

Parameters:
- CNT_W, 16, width of the match and error counters; both saturate at all-ones.
- LOCK_CNT, 2, consecutive +1 matches required in ACQ before entering LOCKED; legal range 1..255.
- STEP, 32'd1, expected increment between consecutive words.

Ports:
- clk  input  1  sampling clock (posedge)
- rst  input  1  synchronous, active-high reset
- enable  input  1  checker active; low forces IDLE
- clear  input  1  synchronous clear of match_cnt/err_cnt (no state change)
- data_in  input  32 (data_s)  sampled word, the data_out field of foo_if
- locked  output  1  high while in LOCKED
- err_pulse  output  1  one-cycle pulse per mismatch detected in LOCKED
- match_cnt  output  CNT_W  words matched while LOCKED
- err_cnt  output  CNT_W  mismatches while LOCKED
- expected  output  32  model's next expected word
- last_data  output  32  most recently sampled word

Behaviour:
- Reset: state=IDLE; locked=0, err_pulse=0, match_cnt=0, err_cnt=0, expected=0, last_data=0, run counter=0. Reset mid-stream discards lock immediately and wins over every other input.
- All outputs are registered. A sample taken at edge N is reflected in the outputs after edge N.
- last_data loads data_in every edge while enable=1 and holds while enable=0.
- IDLE: if enable=1, capture data_in, set expected=data_in+STEP, run=0, and go to ACQ.
- ACQ, data_in==expected: run++ and expected+=STEP. If run+1==LOCK_CNT, go to LOCKED.
- ACQ, mismatch: re-acquire. Set expected=data_in+STEP, run=0, stay in ACQ. No error is counted.
- LOCKED, match: match_cnt++ (saturating) and expected+=STEP.
- LOCKED, mismatch: err_pulse=1 for one cycle and err_cnt++ (saturating). Without the optional feature: stay LOCKED and set expected+=STEP, so the model ignores the bad word.
- enable=0 in any state goes to IDLE next edge. locked=0; counters and expected hold.
- Arithmetic is modulo 2^32. 32'hFFFFFFFF followed by 32'h00000000 is a match (wrap-around).
- Counters stick at {CNT_W{1'b1}}; no rollover.
- clear=1 zeroes both counters. If clear coincides with a match or error in the same cycle, clear wins and the counter becomes 0. err_pulse still fires.
- X/Z on data_in while LOCKED counts as a mismatch, because the compare uses !==.

Optional Feature:
- Macro: FOO_SEQ_CHECKER_RESYNC_EN.
- Defined: a mismatch in LOCKED still pulses err_pulse and increments err_cnt. The FSM then drops to ACQ with expected=data_in+STEP and run=0, and locked falls the following cycle. A stream that jumps once therefore produces exactly one error, followed by re-lock.
- Undefined: the behaviour described above; the model keeps free-running expected.

Decomposition:
- foo_pkg holds:
  - the existing data_s typedef, moved out of global scope;
  - the state enum foo_chk_state_e {IDLE, ACQ, LOCKED};
  - localparam FOO_DATA_W=32.
- One sub-module: foo_sat_cnt. It is a CNT_W-wide saturating counter with inc, clr and synchronous rst, instantiated twice (match and error).

Test Plan:
- rst high for 2 cycles, then enable=1 with 10 words 32'hcafedeca..32'hcafeded3 (LOCK_CNT=2). Expect locked rising after the 3rd sample, match_cnt=7, err_cnt=0, expected=32'hcafeded4.
- Wrap: while locked, drive 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001. Expect no err_pulse, match_cnt +4.
- Single corrupt word while locked: drive 100,101,0xDEAD,103,104.
  - Default build: err_cnt=1, one err_pulse, and 103/104 match.
  - With FOO_SEQ_CHECKER_RESYNC_EN: err_cnt=1, locked drops; 103 is the capture and 104 is run=1, so the stream re-locks at the next matching word.
- Glitch during ACQ: drive 5,6,9,10,11. Expect no errors; lock established after 11; err_cnt=0.
- clear asserted in the same cycle as a mismatch. Expect err_pulse=1 and err_cnt=0 next cycle. Saturation: force CNT_W=4 and run 20 matches, expecting match_cnt=4'hF.
- enable dropped mid-stream, then rst pulsed while locked. Expect IDLE and locked=0 next edge. Counters hold after enable=0; all outputs return to 0 after rst.
